// File: rtl/sign_extend_unit_if.sv
// Operand/result bundle between the extend unit and its producer/consumer.
interface sign_extend_unit_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 64
);
  logic             i_valid;
  logic [IN_W-1:0]  i_num;
  logic [1:0]       i_size;
  logic             i_unsigned;
  logic             o_valid;
  logic [OUT_W-1:0] o_extended;

  modport master (
    output i_valid, i_num, i_size, i_unsigned,
    input  o_valid, o_extended
  );

  modport slave (
    input  i_valid, i_num, i_size, i_unsigned,
    output o_valid, o_extended
  );
endinterface

// File: rtl/sign_extend_unit.sv
// Registered sign/zero extender: widens a byte/half/word/full source field to OUT_W bits.
module sign_extend_unit #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 64
) (
  input logic                i_clk,
  input logic                i_rst_n,
  sign_extend_unit_if.slave  bus
);

  // Low W bits pass through; everything above is the fill bit.
  function automatic logic signed [OUT_W-1:0] extend(
    input logic [IN_W-1:0] num,
    input logic [1:0]      size,
    input logic            uns
  );
    int                      w;
    logic                    fill;
    logic [OUT_W-1:0]        low_mask;
    logic signed [OUT_W-1:0] res;
    case (size)
      2'b00:   w = 8;
      2'b01:   w = 16;
      2'b10:   w = 32;
      default: w = IN_W;
    endcase
    // Shifting by the full width yields 0, so w == OUT_W gives an all-ones mask.
    low_mask = (OUT_W'(1) << w) - OUT_W'(1);
    fill     = ~uns & num[w-1];
    res      = signed'((OUT_W'(num) & low_mask) | (fill ? ~low_mask : '0));
    return res;
  endfunction

  logic                    vld_p1;
  logic signed [OUT_W-1:0] ext_p1;

  // p0 -> p1: capture the extended operand
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1 <= 1'b0;
      ext_p1 <= '0;
    end else begin
      vld_p1 <= bus.i_valid;
      if (bus.i_valid) begin
        ext_p1 <= extend(bus.i_num, bus.i_size, bus.i_unsigned);
      end
    end
  end

  assign bus.o_valid    = vld_p1;
  assign bus.o_extended = ext_p1;

endmodule

// File: tb/tb_sign_extend_unit.sv
// Scoreboard bench for sign_extend_unit: directed vectors, monitor pops expected results.
module tb_sign_extend_unit;
  localparam int IN_W  = 32;
  localparam int OUT_W = 64;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [OUT_W-1:0] exp_q[$];

  sign_extend_unit_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  sign_extend_unit #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send(input logic [IN_W-1:0] num, input logic [1:0] size, input logic uns,
                      input logic [OUT_W-1:0] exp);
    @(posedge clk);
    #1;
    bus.i_valid    = 1'b1;
    bus.i_num      = num;
    bus.i_size     = size;
    bus.i_unsigned = uns;
    exp_q.push_back(exp);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  // Monitor: every presented result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.o_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=%h required=no_output", bus.o_extended);
      end else begin
        check("result", bus.o_extended, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n          = 1'b0;
    bus.i_valid    = 1'b1;
    bus.i_num      = 32'hFFFF_FFFF;
    bus.i_size     = 2'b10;
    bus.i_unsigned = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_valid", 64'(bus.o_valid), 64'h0);
      check("reset_data", bus.o_extended, 64'h0);
    end

    // Release with the all-ones word still applied: first capture on the next edge.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    check("release_not_early", 64'(bus.o_valid), 64'h0);

    send(32'd31,         2'b10, 1'b0, 64'h0000_0000_0000_001F);
    send(32'hFFFF_FFF1,  2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1);
    send(32'h1234_5680,  2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FF80);
    send(32'h1234_5680,  2'b00, 1'b1, 64'h0000_0000_0000_0080);
    send(32'h0001_8000,  2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_8000);
    send(32'h0001_8000,  2'b01, 1'b1, 64'h0000_0000_0000_8000);
    send(32'h1234_567F,  2'b00, 1'b0, 64'h0000_0000_0000_007F);
    send(32'h7FFF_FFFF,  2'b10, 1'b0, 64'h0000_0000_7FFF_FFFF);
    send(32'h8000_0000,  2'b10, 1'b0, 64'hFFFF_FFFF_8000_0000);
    send(32'h8000_0000,  2'b10, 1'b1, 64'h0000_0000_8000_0000);
    send(32'h0000_0000,  2'b10, 1'b0, 64'h0000_0000_0000_0000);
    send(32'h8000_0000,  2'b11, 1'b0, 64'hFFFF_FFFF_8000_0000);
    send(32'hFFFF_FFFF,  2'b11, 1'b1, 64'h0000_0000_FFFF_FFFF);
    idle();
    idle();

    // Streaming, then hold.
    send(32'd31,         2'b10, 1'b0, 64'h0000_0000_0000_001F);
    send(32'hFFFF_FFF1,  2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1);
    send(32'd7,          2'b10, 1'b0, 64'h0000_0000_0000_0007);
    idle();
    @(negedge clk);
    @(negedge clk);
    check("hold_valid", 64'(bus.o_valid), 64'h0);
    check("hold_data", bus.o_extended, 64'h0000_0000_0000_0007);

    // Mid-stream reset: the captured result is discarded at once.
    @(posedge clk);
    #1;
    bus.i_valid = 1'b1;
    bus.i_num   = 32'd5;
    bus.i_size  = 2'b10;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_valid", 64'(bus.o_valid), 64'h0);
    check("midreset_data", bus.o_extended, 64'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("midreset_hold_valid", 64'(bus.o_valid), 64'h0);
    end
    bus.i_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_reset_valid", 64'(bus.o_valid), 64'h0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL outstanding actual=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
